// File: rtl/matrix_construct_stream.sv
// Streams row-major matrix entries into single-entry store writes, optionally transposed.
// Optional square zero-padding is built when MATRIX_CONSTRUCT_SQUARE_PAD_EN is defined.
module matrix_construct_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  m_dim,
  input  logic [DIM_W-1:0]  n_dim,
  input  logic              transpose,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wr_ready,
  output logic              write,
  output logic [DIM_W-1:0]  m_addr,
  output logic [DIM_W-1:0]  n_addr,
  output logic [DATA_W-1:0] matrix_entry,
  output logic              done,
  output logic              err_dim,
  output logic              q_Idle,
  output logic              q_Construct,
  output logic              q_Pad,
  output logic              q_Done
);

  typedef enum logic [3:0] {
    StIdle      = 4'b0001,
    StConstruct = 4'b0010,
    StPad       = 4'b0100,
    StDone      = 4'b1000
  } state_e;

  localparam logic [DIM_W-1:0] One = DIM_W'(1);

  state_e state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, i_q, i_d, j_q, j_d;
  logic              tr_q, tr_d;
  logic              write_q, write_d, done_q, done_d, err_q, err_d;
  logic [DIM_W-1:0]  m_addr_q, m_addr_d, n_addr_q, n_addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A write slot is free when nothing is pending or the pending write retires now.
  logic slot, accept, last_in, row_end;
  assign slot    = ~write_q | wr_ready;
  assign accept  = in_valid & in_ready;
  assign row_end = (j_q == n_q - One);
  assign last_in = (i_q == m_q - One) && row_end;

`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
  logic [DIM_W-1:0] s_dim, pad_j0;
  logic             need_pad, last_pad;
  assign s_dim    = (m_q > n_q) ? m_q : n_q;
  assign pad_j0   = (m_q < n_q) ? '0 : n_q;
  assign need_pad = (m_q != n_q);
  assign last_pad = (i_q == s_dim - One) && (j_q == s_dim - One);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start && m_dim != '0 && n_dim != '0) state_d = StConstruct;
      StConstruct: begin
        if (accept && last_in) begin
`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
          state_d = need_pad ? StPad : StDone;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
      StPad:       if (slot && last_pad) state_d = StDone;
`endif
      StDone:      if (slot) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    q_Idle      = (state_q == StIdle);
    q_Construct = (state_q == StConstruct);
`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
    q_Pad       = (state_q == StPad);
`else
    q_Pad       = 1'b0;
`endif
    q_Done      = (state_q == StDone);
    in_ready    = q_Construct & slot;
  end

  always_comb begin
    m_d = m_q;  n_d = n_q;  tr_d = tr_q;  i_d = i_q;  j_d = j_q;
    m_addr_d = m_addr_q;  n_addr_d = n_addr_q;  data_d = data_q;
    write_d = write_q & ~wr_ready;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (m_dim != '0 && n_dim != '0) begin
            m_d = m_dim;  n_d = n_dim;  tr_d = transpose;  i_d = '0;  j_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StConstruct: begin
        if (accept) begin
          write_d  = 1'b1;
          m_addr_d = tr_q ? j_q : i_q;
          n_addr_d = tr_q ? i_q : j_q;
          data_d   = in_data;
          if (row_end) begin
            j_d = '0;
            i_d = i_q + One;
          end else begin
            j_d = j_q + One;
          end
`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
          // Tall matrices pad the right-hand columns of every row, starting from row 0.
          if (last_in && m_q > n_q) begin
            i_d = '0;
            j_d = n_q;
          end
`endif
        end
      end
`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
      StPad: begin
        if (slot) begin
          write_d  = 1'b1;
          m_addr_d = tr_q ? j_q : i_q;
          n_addr_d = tr_q ? i_q : j_q;
          data_d   = '0;
          if (j_q == s_dim - One) begin
            j_d = pad_j0;
            i_d = i_q + One;
          end else begin
            j_d = j_q + One;
          end
        end
      end
`endif
      StDone: begin
        if (slot) begin
          done_d  = 1'b1;
          write_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;  n_q <= '0;  tr_q <= 1'b0;  i_q <= '0;  j_q <= '0;
      write_q <= 1'b0;  m_addr_q <= '0;  n_addr_q <= '0;  data_q <= '0;
      done_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      m_q <= m_d;  n_q <= n_d;  tr_q <= tr_d;  i_q <= i_d;  j_q <= j_d;
      write_q <= write_d;  m_addr_q <= m_addr_d;  n_addr_q <= n_addr_d;  data_q <= data_d;
      done_q <= done_d;  err_q <= err_d;
    end
  end

  assign write        = write_q;
  assign m_addr       = m_addr_q;
  assign n_addr       = n_addr_q;
  assign matrix_entry = data_q;
  assign done         = done_q;
  assign err_dim      = err_q;

endmodule

// File: tb/tb_matrix_construct_stream.sv
// Directed bench for matrix_construct_stream; pad expectations follow
// MATRIX_CONSTRUCT_SQUARE_PAD_EN.
module tb_matrix_construct_stream;

  logic        clk = 1'b0;
  logic        reset, start, transpose, in_valid, wr_ready;
  logic [7:0]  m_dim, n_dim;
  logic [31:0] in_data;
  logic        in_ready, write, done, err_dim, q_Idle, q_Construct, q_Pad, q_Done;
  logic [7:0]  m_addr, n_addr;
  logic [31:0] matrix_entry;

  int checks = 0;
  int fails  = 0;
  logic [47:0] log_q[$];
  logic [47:0] exp_plain[$];
  logic [47:0] exp_tr[$];
  int dc;

`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
  localparam int DoneEdge = 10;
`else
  localparam int DoneEdge = 7;
`endif

  matrix_construct_stream dut (
    .clk(clk), .reset(reset), .start(start), .m_dim(m_dim), .n_dim(n_dim),
    .transpose(transpose), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_ready(wr_ready), .write(write), .m_addr(m_addr), .n_addr(n_addr),
    .matrix_entry(matrix_entry), .done(done), .err_dim(err_dim), .q_Idle(q_Idle),
    .q_Construct(q_Construct), .q_Pad(q_Pad), .q_Done(q_Done)
  );

  always #5 clk = ~clk;

  // Every retiring write, sampled mid-cycle.
  always @(negedge clk)
    if (!reset && write && wr_ready) log_q.push_back({m_addr, n_addr, matrix_entry});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input logic [47:0] exp[$]);
    chk({tag, "_count"}, 64'(log_q.size()), 64'(exp.size()));
    foreach (exp[k]) if (k < log_q.size()) chk(tag, log_q[k], exp[k]);
  endtask

  // Called just after a rising edge; returns the edge index whose following cycle shows done.
  task automatic run_load(input int m, input int n, input bit tr, input bit bp, input bit late,
                          output int done_cycle);
    int sent = 0;
    int cyc = 0;
    bit acc, have_prev;
    logic [63:0] prev;
    have_prev = 1'b0;
    prev = '0;
    done_cycle = -1;
    start = 1'b1; m_dim = 8'(m); n_dim = 8'(n); transpose = tr;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cycle < 0 && cyc < 200) begin
      in_valid = (sent < m * n) && (!bp || (cyc % 3 != 1));
      in_data  = 32'(sent + 1);
      wr_ready = !bp || (cyc % 2 == 0);
      if (late && cyc == 2) begin
        start = 1'b1; m_dim = 8'd1; n_dim = 8'd1; transpose = ~tr;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (have_prev) chk("stall_hold", {15'd0, write, m_addr, n_addr, matrix_entry}, prev);
      have_prev = write && !wr_ready;
      prev = {15'd0, write, m_addr, n_addr, matrix_entry};
      if (write && !wr_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (done) done_cycle = cyc;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; wr_ready = 1'b1;
    chk("done_seen", 64'(done_cycle >= 0), 64'd1);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(q_Idle), 64'd1);
  endtask

  initial begin
    exp_plain = '{{8'd0, 8'd0, 32'd1}, {8'd0, 8'd1, 32'd2}, {8'd1, 8'd0, 32'd3},
                  {8'd1, 8'd1, 32'd4}, {8'd2, 8'd0, 32'd5}, {8'd2, 8'd1, 32'd6}};
    exp_tr    = '{{8'd0, 8'd0, 32'd1}, {8'd1, 8'd0, 32'd2}, {8'd0, 8'd1, 32'd3},
                  {8'd1, 8'd1, 32'd4}, {8'd0, 8'd2, 32'd5}, {8'd1, 8'd2, 32'd6}};
`ifdef MATRIX_CONSTRUCT_SQUARE_PAD_EN
    exp_plain.push_back({8'd0, 8'd2, 32'd0});
    exp_plain.push_back({8'd1, 8'd2, 32'd0});
    exp_plain.push_back({8'd2, 8'd2, 32'd0});
    exp_tr.push_back({8'd2, 8'd0, 32'd0});
    exp_tr.push_back({8'd2, 8'd1, 32'd0});
    exp_tr.push_back({8'd2, 8'd2, 32'd0});
`endif
    reset = 1'b1; start = 1'b0; transpose = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    m_dim = '0; n_dim = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_n_addr", 64'(n_addr), 64'd0);
    chk("rst_entry", 64'(matrix_entry), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_dim), 64'd0);
    chk("rst_state", 64'({q_Idle, q_Construct, q_Pad, q_Done}), 64'b1000);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain 3x2
    log_q.delete();
    run_load(3, 2, 1'b0, 1'b0, 1'b0, dc);
    chk("plain_done_edge", 64'(dc), 64'(DoneEdge));
    check_log("plain", exp_plain);

    // Transposed 3x2
    log_q.delete();
    run_load(3, 2, 1'b1, 1'b0, 1'b0, dc);
    chk("tr_done_edge", 64'(dc), 64'(DoneEdge));
    check_log("tr", exp_tr);

    // Backpressure, gapped input, and a late start that must be ignored
    log_q.delete();
    run_load(3, 2, 1'b0, 1'b1, 1'b1, dc);
    check_log("bp", exp_plain);

    // Zero dimension
    log_q.delete();
    start = 1'b1; m_dim = 8'd3; n_dim = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", 64'(err_dim), 64'd1);
    chk("err_idle", 64'(q_Idle), 64'd1);
    chk("err_no_write", 64'(write), 64'd0);
    @(posedge clk); #1;
    chk("err_one_cycle", 64'(err_dim), 64'd0);
    chk("err_still_idle", 64'(q_Idle), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("err_writes", 64'(log_q.size()), 64'd0);

    // Reset after three entries
    start = 1'b1; m_dim = 8'd3; n_dim = 8'd2; transpose = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = 32'(k); wr_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_write", 64'(write), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_write", 64'(write), 64'd0);
    chk("mid_rst_addr", 64'({m_addr, n_addr}), 64'd0);
    chk("mid_rst_entry", 64'(matrix_entry), 64'd0);
    chk("mid_rst_state", 64'({q_Idle, q_Construct, q_Pad, q_Done}), 64'b1000);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    log_q.delete();
    run_load(3, 2, 1'b0, 1'b0, 1'b0, dc);
    chk("rerun_done_edge", 64'(dc), 64'(DoneEdge));
    check_log("rerun", exp_plain);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
